// File: rtl/hilo_ctrl_if.sv
// Handshake bus between hilo_ctrl and the multi-cycle multiplier/divider.
// master = sequencing stage (drives starts and operands), slave = arithmetic units.
interface hilo_ctrl_if;
    logic        mult_start;
    logic        div_start;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        mult_busy;
    logic [31:0] mult_hi;
    logic [31:0] mult_lo;
    logic        div_busy;
    logic [31:0] div_rem;
    logic [31:0] div_quot;

    modport master (
        output mult_start, div_start, op_a, op_b,
        input  mult_busy, mult_hi, mult_lo, div_busy, div_rem, div_quot
    );

    modport slave (
        input  mult_start, div_start, op_a, op_b,
        output mult_busy, mult_hi, mult_lo, div_busy, div_rem, div_quot
    );
endinterface

// File: rtl/hilo_ctrl.sv
// HI/LO sequencing stage: launches MULT/DIV on the external units, waits for
// completion (with a timeout), captures the result and stalls the pipeline meanwhile.
module hilo_ctrl #(
    parameter int unsigned TIMEOUT = 40,
    parameter int unsigned CW      = 6
) (
    input  logic               i_clock,
    input  logic               i_reset_n,
    input  logic               i_op_valid,
    input  logic [1:0]         i_op_sel,
    input  logic [31:0]        i_rs_val,
    input  logic [31:0]        i_rt_val,
    input  logic               i_hi_we,
    input  logic               i_lo_we,
    input  logic [31:0]        i_wdata,
    hilo_ctrl_if.master        unit_if,
    output logic [31:0]        o_hi,
    output logic [31:0]        o_lo,
    output logic               o_stall,
    output logic               o_done,
    output logic               o_div_zero,
    output logic               o_timeout
);

    typedef enum logic [1:0] {StIdle, StLaunch, StWait, StCapture} state_e;

    state_e          r_state;
    state_e          w_state_next;
    logic            r_unit_div;
    logic [CW-1:0]   r_cnt;
    logic [31:0]     r_op_a;
    logic [31:0]     r_op_b;
    logic [31:0]     r_hi;
    logic [31:0]     r_lo;
    logic            r_div_zero;
    logic            r_timeout;

    logic            w_is_idle;
    logic            w_accept;
    logic            w_div_zero_req;
    logic            w_unit_busy;
    logic            w_first_wait;
    logic            w_expired;
    logic            w_set_timeout;
    logic            w_stall;
    logic            w_done;
    logic            w_mult_start;
    logic            w_div_start;

    assign w_is_idle      = (r_state == StIdle);
    assign w_accept       = w_is_idle && i_op_valid &&
                            ((i_op_sel == 2'b00) || ((i_op_sel == 2'b01) && (i_rt_val != '0)));
    assign w_div_zero_req = w_is_idle && i_op_valid && (i_op_sel == 2'b01) && (i_rt_val == '0);
    assign w_unit_busy    = r_unit_div ? unit_if.div_busy : unit_if.mult_busy;
    // Busy lags start by one cycle, so the first WAIT cycle (counter still 0) is blind.
    assign w_first_wait   = (r_cnt == '0);
    assign w_expired      = (r_cnt == CW'(TIMEOUT - 1));

    // Next-state logic and state-decoded outputs.
    always_comb begin
        w_state_next  = r_state;
        w_set_timeout = 1'b0;
        w_stall       = 1'b0;
        w_done        = 1'b0;
        w_mult_start  = 1'b0;
        w_div_start   = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (w_accept) begin
                    w_stall      = 1'b1;
                    w_state_next = StLaunch;
                end
            end
            StLaunch: begin
                w_stall      = 1'b1;
                w_mult_start = !r_unit_div;
                w_div_start  = r_unit_div;
                w_state_next = StWait;
            end
            StWait: begin
                w_stall = 1'b1;
                if (!w_first_wait) begin
                    if (!w_unit_busy) begin
                        w_state_next = StCapture;
                    end else if (w_expired) begin
                        w_state_next  = StCapture;
                        w_set_timeout = 1'b1;
                    end
                end
            end
            StCapture: begin
                w_stall      = 1'b1;
                w_done       = 1'b1;
                w_state_next = StIdle;
            end
            default: w_state_next = StIdle;
        endcase
    end

    // State register.
    always_ff @(posedge i_clock) begin
        if (!i_reset_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // WAIT cycle counter, cleared during LAUNCH.
    always_ff @(posedge i_clock) begin
        if (!i_reset_n) begin
            r_cnt <= '0;
        end else if (r_state == StLaunch) begin
            r_cnt <= '0;
        end else if (r_state == StWait) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Operand and unit-select latch, updated only when an op is accepted.
    always_ff @(posedge i_clock) begin
        if (!i_reset_n) begin
            r_op_a     <= '0;
            r_op_b     <= '0;
            r_unit_div <= 1'b0;
        end else if (w_accept) begin
            r_op_a     <= i_rs_val;
            r_op_b     <= i_rt_val;
            r_unit_div <= i_op_sel[0];
        end
    end

    // HI/LO: MTHI/MTLO in IDLE, unit result at the end of CAPTURE.
    always_ff @(posedge i_clock) begin
        if (!i_reset_n) begin
            r_hi <= '0;
            r_lo <= '0;
        end else if (w_is_idle) begin
            if (i_hi_we) r_hi <= i_wdata;
            if (i_lo_we) r_lo <= i_wdata;
        end else if (r_state == StCapture) begin
            r_hi <= r_unit_div ? unit_if.div_rem  : unit_if.mult_hi;
            r_lo <= r_unit_div ? unit_if.div_quot : unit_if.mult_lo;
        end
    end

    // Status flags: divide-by-zero pulse and sticky timeout.
    always_ff @(posedge i_clock) begin
        if (!i_reset_n) begin
            r_div_zero <= 1'b0;
            r_timeout  <= 1'b0;
        end else begin
            r_div_zero <= w_div_zero_req;
            if (w_accept) begin
                r_timeout <= 1'b0;
            end else if (w_set_timeout) begin
                r_timeout <= 1'b1;
            end
        end
    end

    assign unit_if.mult_start = w_mult_start;
    assign unit_if.div_start  = w_div_start;
    assign unit_if.op_a       = r_op_a;
    assign unit_if.op_b       = r_op_b;
    assign o_hi               = r_hi;
    assign o_lo               = r_lo;
    assign o_stall            = w_stall;
    assign o_done             = w_done;
    assign o_div_zero         = r_div_zero;
    assign o_timeout          = r_timeout;

endmodule

// File: tb/tb_hilo_ctrl.sv
// Self-checking bench for hilo_ctrl with behavioural multiplier/divider models.
module tb_hilo_ctrl;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        op_valid = 1'b0;
    logic [1:0]  op_sel = 2'b00;
    logic [31:0] rs_val = '0;
    logic [31:0] rt_val = '0;
    logic        hi_we = 1'b0;
    logic        lo_we = 1'b0;
    logic [31:0] wdata = '0;
    logic [31:0] hi, lo;
    logic        stall, done, div_zero, timeout;

    hilo_ctrl_if bus ();

    hilo_ctrl #(.TIMEOUT(40), .CW(6)) dut (
        .i_clock    (clk),
        .i_reset_n  (reset_n),
        .i_op_valid (op_valid),
        .i_op_sel   (op_sel),
        .i_rs_val   (rs_val),
        .i_rt_val   (rt_val),
        .i_hi_we    (hi_we),
        .i_lo_we    (lo_we),
        .i_wdata    (wdata),
        .unit_if    (bus),
        .o_hi       (hi),
        .o_lo       (lo),
        .o_stall    (stall),
        .o_done     (done),
        .o_div_zero (div_zero),
        .o_timeout  (timeout)
    );

    always #5 clk = ~clk;

    // Unit models: busy drops cur_lat cycles after the start pulse.
    int          cur_lat = 2;
    bit          m_stuck = 1'b0;
    int          m_cnt = 0;
    int          d_cnt = 0;
    logic [63:0] m_res = '0;
    logic [31:0] d_q = '0;
    logic [31:0] d_r = '0;

    always @(posedge clk) begin
        if (bus.mult_start) begin
            m_res <= 64'(longint'($signed(bus.op_a)) * longint'($signed(bus.op_b)));
            m_cnt <= cur_lat - 1;
        end else if (m_cnt > 0) begin
            m_cnt <= m_cnt - 1;
        end
        if (bus.div_start) begin
            if (bus.op_b != 0) begin
                d_q <= $signed(bus.op_a) / $signed(bus.op_b);
                d_r <= $signed(bus.op_a) % $signed(bus.op_b);
            end
            d_cnt <= cur_lat - 1;
        end else if (d_cnt > 0) begin
            d_cnt <= d_cnt - 1;
        end
    end

    assign bus.mult_busy = m_stuck || (m_cnt != 0);
    assign bus.mult_hi   = m_res[63:32];
    assign bus.mult_lo   = m_res[31:0];
    assign bus.div_busy  = (d_cnt != 0);
    assign bus.div_rem   = d_r;
    assign bus.div_quot  = d_q;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic mt_write(input logic we_hi, input logic we_lo, input logic [31:0] d);
        @(negedge clk);
        hi_we = we_hi;
        lo_we = we_lo;
        wdata = d;
        @(negedge clk);
        hi_we = 1'b0;
        lo_we = 1'b0;
    endtask

    // Results of the last run_op.
    int          r_stall, r_ms, r_ds, r_done, r_dz;
    logic        r_to1;
    logic [31:0] r_lo_probe;
    bit          r_fin;

    // Issue one request and watch it until the first unstalled cycle after it.
    // mtlo_at >= 0 pulses an MTLO (wdata 0xAAAA5555) in that cycle.
    task automatic run_op(input logic [1:0] sel, input logic [31:0] rs, input logic [31:0] rt,
                          input int lat, input int mtlo_at);
        cur_lat = lat;
        r_stall = 0; r_ms = 0; r_ds = 0; r_done = 0; r_dz = 0;
        r_to1 = 1'bx; r_lo_probe = 'x; r_fin = 1'b0;
        @(negedge clk);
        op_valid = 1'b1;
        op_sel   = sel;
        rs_val   = rs;
        rt_val   = rt;
        for (int c = 0; c < 200; c++) begin
            if (c == mtlo_at) begin
                lo_we = 1'b1;
                wdata = 32'hAAAA5555;
            end
            #1;
            if (stall)           r_stall++;
            if (bus.mult_start)  r_ms++;
            if (bus.div_start)   r_ds++;
            if (done)            r_done++;
            if (div_zero)        r_dz++;
            if (c == 1)          r_to1 = timeout;
            if (c == mtlo_at + 1) r_lo_probe = lo;
            if (c > 0 && !stall) begin
                r_fin = 1'b1;
                break;
            end
            @(negedge clk);
            op_valid = 1'b0;
            lo_we    = 1'b0;
        end
        op_valid = 1'b0;
        lo_we    = 1'b0;
        if (!r_fin) begin
            n_cmp++;
            n_err++;
            $display("FAIL op_complete: still stalled after 200 cycles, expected completion");
        end
    endtask

    typedef struct {
        logic [1:0]  sel;
        logic [31:0] rs;
        logic [31:0] rt;
        int          lat;
        logic [31:0] pre_hi;
        logic [31:0] pre_lo;
        int          e_stall;
        int          e_ms;
        int          e_ds;
        int          e_done;
        int          e_dz;
        logic [31:0] e_hi;
        logic [31:0] e_lo;
    } vec_t;

    vec_t vecs [8];

    initial begin
        // sel rs rt lat pre_hi pre_lo | stall ms ds done dz hi lo
        vecs[0] = '{2'b00, 32'd7, 32'hFFFFFFFD, 32, 32'h0, 32'h0,
                    35, 1, 0, 1, 0, 32'hFFFFFFFF, 32'hFFFFFFEB};
        vecs[1] = '{2'b01, 32'd100, 32'd7, 10, 32'h1, 32'h1,
                    13, 0, 1, 1, 0, 32'd2, 32'd14};
        vecs[2] = '{2'b01, 32'd5, 32'd0, 10, 32'h11, 32'h22,
                    0, 0, 0, 0, 1, 32'h11, 32'h22};
        vecs[3] = '{2'b00, 32'd3, 32'd4, 1, 32'h5, 32'h5,
                    5, 1, 0, 1, 0, 32'd0, 32'd12};
        vecs[4] = '{2'b10, 32'd9, 32'd9, 4, 32'h33, 32'h44,
                    0, 0, 0, 0, 0, 32'h33, 32'h44};
        vecs[5] = '{2'b01, 32'hFFFFFFF9, 32'd2, 5, 32'h0, 32'h0,
                    8, 0, 1, 1, 0, 32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[6] = '{2'b00, 32'h00010000, 32'h00010000, 2, 32'h0, 32'h0,
                    5, 1, 0, 1, 0, 32'd1, 32'd0};
        vecs[7] = '{2'b11, 32'd1, 32'd1, 3, 32'h66, 32'h77,
                    0, 0, 0, 0, 0, 32'h66, 32'h77};

        // Reset state.
        repeat (3) @(negedge clk);
        #1;
        check("rst_hi", hi, 32'h0);
        check("rst_lo", lo, 32'h0);
        check("rst_stall", 32'(stall), 32'h0);
        check("rst_done", 32'(done), 32'h0);
        check("rst_div_zero", 32'(div_zero), 32'h0);
        check("rst_timeout", 32'(timeout), 32'h0);
        check("rst_starts", 32'({bus.mult_start, bus.div_start}), 32'h0);
        check("rst_op_a", bus.op_a, 32'h0);
        check("rst_op_b", bus.op_b, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;

        // MTHI in IDLE lands at the next edge; LO untouched.
        mt_write(1'b1, 1'b0, 32'hDEADBEEF);
        #1;
        check("mthi_hi", hi, 32'hDEADBEEF);
        check("mthi_lo", lo, 32'h0);
        // Both enables: both registers take wdata.
        mt_write(1'b1, 1'b1, 32'h12345678);
        #1;
        check("mtboth_hi", hi, 32'h12345678);
        check("mtboth_lo", lo, 32'h12345678);

        // Table-driven ops.
        for (int i = 0; i < 8; i++) begin
            mt_write(1'b1, 1'b0, vecs[i].pre_hi);
            mt_write(1'b0, 1'b1, vecs[i].pre_lo);
            run_op(vecs[i].sel, vecs[i].rs, vecs[i].rt, vecs[i].lat, -10);
            check($sformatf("v%0d_stall_cycles", i), 32'(r_stall), 32'(vecs[i].e_stall));
            check($sformatf("v%0d_mult_start", i), 32'(r_ms), 32'(vecs[i].e_ms));
            check($sformatf("v%0d_div_start", i), 32'(r_ds), 32'(vecs[i].e_ds));
            check($sformatf("v%0d_done", i), 32'(r_done), 32'(vecs[i].e_done));
            check($sformatf("v%0d_div_zero", i), 32'(r_dz), 32'(vecs[i].e_dz));
            check($sformatf("v%0d_hi", i), hi, vecs[i].e_hi);
            check($sformatf("v%0d_lo", i), lo, vecs[i].e_lo);
            if (vecs[i].e_ms + vecs[i].e_ds > 0) begin
                check($sformatf("v%0d_op_a", i), bus.op_a, vecs[i].rs);
                check($sformatf("v%0d_op_b", i), bus.op_b, vecs[i].rt);
            end
        end

        // Stuck multiplier: forced capture after 40 WAIT cycles, sticky timeout.
        m_stuck = 1'b1;
        run_op(2'b00, 32'd5, 32'd6, 1, -10);
        m_stuck = 1'b0;
        check("to_stall_cycles", 32'(r_stall), 32'd43);
        check("to_done", 32'(r_done), 32'd1);
        check("to_flag", 32'(timeout), 32'd1);
        check("to_hi", hi, 32'd0);
        check("to_lo", lo, 32'd30);
        repeat (3) @(negedge clk);
        #1;
        check("to_flag_held", 32'(timeout), 32'd1);

        // Next accepted op clears timeout; an MTLO during WAIT is dropped.
        run_op(2'b00, 32'd2, 32'd3, 20, 6);
        check("to_cleared_on_accept", 32'(r_to1), 32'd0);
        check("mtlo_in_wait_dropped", r_lo_probe, 32'd30);
        check("after_to_stall_cycles", 32'(r_stall), 32'd23);
        check("after_to_lo", lo, 32'd6);
        check("after_to_flag", 32'(timeout), 32'd0);

        // Reset in the middle of WAIT.
        cur_lat = 30;
        @(negedge clk);
        op_valid = 1'b1; op_sel = 2'b00; rs_val = 32'd9; rt_val = 32'd9;
        @(negedge clk);
        op_valid = 1'b0;
        repeat (8) @(negedge clk);
        #1;
        check("pre_rst_stall", 32'(stall), 32'd1);
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        check("midrst_stall", 32'(stall), 32'd0);
        check("midrst_hi", hi, 32'd0);
        check("midrst_lo", lo, 32'd0);
        check("midrst_op_a", bus.op_a, 32'd0);
        @(negedge clk);
        #1;
        check("midrst_still_idle", 32'(stall | done), 32'd0);
        run_op(2'b00, 32'd3, 32'd4, 3, -10);
        check("postrst_stall_cycles", 32'(r_stall), 32'd6);
        check("postrst_hi", hi, 32'd0);
        check("postrst_lo", lo, 32'd12);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

endmodule

// File: doc/hilo_ctrl.md
Name: hilo_ctrl

Overview:
- Sequencing and result stage placed directly downstream of the multi-cycle multiplier and divider.
- Accepts MULT/DIV requests from the control unit and pulses the unit's start.
- Waits on busy, then captures the 64-bit result into the architectural HI/LO registers.
- Stalls the pipeline while an operation runs; also services MTHI/MTLO writes and flags divide-by-zero and unit timeouts.

Parameters:
- TIMEOUT, 40, max cycles spent in WAIT before a forced capture; must be ≥ 34.
- CW, 6, width of the WAIT cycle counter; must satisfy 2^CW > TIMEOUT.

Ports:
- clock  in  1  system clock, rising edge
- reset_n  in  1  synchronous active-low reset
- op_valid  in  1  request strobe, sampled in IDLE only
- op_sel  in  2  00=MULT, 01=DIV; 10/11 are ignored (no action)
- rs_val  in  32  operand A: multiplicand or dividend
- rt_val  in  32  operand B: multiplier or divisor
- hi_we  in  1  MTHI write enable
- lo_we  in  1  MTLO write enable
- wdata  in  32  MTHI/MTLO data
- mult_start  out  1  one-cycle start pulse to the multiplier
- div_start  out  1  one-cycle start pulse to the divider
- op_a  out  32  latched operand A, held stable for the whole operation
- op_b  out  32  latched operand B, held stable for the whole operation
- mult_busy  in  1  multiplier busy
- mult_hi  in  32  multiplier result, high word
- mult_lo  in  32  multiplier result, low word
- div_busy  in  1  divider busy
- div_rem  in  32  divider remainder
- div_quot  in  32  divider quotient
- hi  out  32  HI register
- lo  out  32  LO register
- stall  out  1  pipeline stall
- done  out  1  capture cycle indicator
- div_zero  out  1  one-cycle pulse: DIV requested with divisor 0
- timeout  out  1  sticky flag: unit timed out; cleared on next accepted op or on reset

Behaviour:
- Reset (reset_n=0 at a rising edge), from any state including mid-operation:
  - state=IDLE; hi, lo, op_a, op_b = 0; counter = 0.
  - mult_start, div_start, done, div_zero, timeout = 0.
  - The in-flight result is discarded; a busy unit is simply ignored.
- States: IDLE, LAUNCH, WAIT, CAPTURE.
- IDLE:
  - An op is accepted when op_valid=1 and op_sel is 00, or op_sel is 01 with rt_val≠0.
  - On accept: latch rs_val→op_a and rt_val→op_b, record the unit, clear timeout, go to LAUNCH.
  - DIV with rt_val=0: no launch; div_zero=1 for the next cycle; hi/lo unchanged; stay in IDLE.
  - op_sel 10/11: no effect.
- LAUNCH:
  - The selected start output is high for exactly this cycle; the other start stays 0.
  - Counter cleared. Next state WAIT.
- WAIT:
  - Counter increments each cycle.
  - Busy is ignored on the first WAIT cycle, because the unit's busy is valid only one cycle after start.
  - From the second WAIT cycle: selected busy=0 → CAPTURE.
  - Counter reaching TIMEOUT while busy is still 1 → CAPTURE and set timeout=1.
- CAPTURE:
  - done=1 (combinational on state).
  - At the closing edge: MULT → hi←mult_hi, lo←mult_lo; DIV → hi←div_rem, lo←div_quot.
  - Next state IDLE.
- stall:
  - Combinationally 1 in IDLE when an op is being accepted.
  - 1 throughout LAUNCH, WAIT and CAPTURE.
  - 0 otherwise, including the div_zero case.
  - New HI/LO values are readable the first cycle stall=0.
- Latency: accept edge → LAUNCH → WAIT (≥2 cycles) → CAPTURE. For a unit whose busy drops N cycles after start, the op takes N+3 cycles from accept to first unstalled cycle.
- MTHI/MTLO:
  - Honoured only in IDLE; the write takes effect at the next edge.
  - Ignored (dropped) in any other state; the pipeline is stalled, so none are issued.
  - Simultaneous with an accepted op: the write happens, then the later capture overwrites it.
  - hi_we and lo_we both high: both registers take wdata.
- op_valid outside IDLE is ignored; there is no queue.
- op_a and op_b change only on accept.

Test Plan:
- MULT rs=7, rt=0xFFFFFFFD; model busy for 32 cycles, result hi=0xFFFFFFFF, lo=0xFFFFFFEB → mult_start high exactly 1 cycle; stall high 35 cycles; hi/lo updated; div_start never toggles.
- DIV rs=100, rt=7 → div_start pulses once; after capture hi=2, lo=14; done high exactly 1 cycle.
- DIV rs=5, rt=0 with hi=0x11, lo=0x22 preloaded → div_zero pulses 1 cycle; stall stays 0; hi=0x11, lo=0x22; no start pulses.
- MULT with mult_busy stuck at 1 → capture after TIMEOUT=40 WAIT cycles; timeout=1 and held until the next accepted op clears it.
- MTHI wdata=0xDEADBEEF in IDLE → hi=0xDEADBEEF next cycle. MTLO asserted during WAIT → lo unchanged.
- reset_n=0 during WAIT of a MULT → next cycle state IDLE, hi=lo=0, stall=0; a following MULT 3×4 completes with lo=12, hi=0.
